// File: rtl/exu_stage.sv
// Execute pipeline stage: operand ALU, branch/jump resolution and a
// registered valid/ready output carrying writeback data and a redirect pulse.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef EXU_OPT_WIDTH
`define EXU_OPT_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_SUBU 4'h2
`define ALU_AND  4'h3
`define ALU_OR   4'h4
`define ALU_XOR  4'h5
`define ALU_SLL  4'h6
`define ALU_SRL  4'h7
`define ALU_SRA  4'h8
`endif

// Combinational ALU; the borrow bit is the unsigned src1 < src2 flag of SUB/SUBU.
module exu_alu #(
    parameter int XLEN  = `CPU_WIDTH,
    parameter int OPT_W = `EXU_OPT_WIDTH
) (
    input  logic [OPT_W-1:0] i_opt,
    input  logic [XLEN-1:0]  i_src1,
    input  logic [XLEN-1:0]  i_src2,
    output logic [XLEN-1:0]  o_res,
    output logic             o_sububit
);
    localparam int SH_W = $clog2(XLEN);

    logic [XLEN:0]   diff;
    logic [SH_W-1:0] shamt;

    assign diff  = {1'b0, i_src1} - {1'b0, i_src2};
    assign shamt = i_src2[SH_W-1:0];

    // Opcode decode; unknown opcodes produce zero.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_res     = '0;
        o_sububit = 1'b0;
        case (i_opt)
            `ALU_ADD:            o_res = i_src1 + i_src2;
            `ALU_SUB, `ALU_SUBU: begin
                o_res     = diff[XLEN-1:0];
                o_sububit = diff[XLEN];
            end
            `ALU_AND:            o_res = i_src1 & i_src2;
            `ALU_OR:             o_res = i_src1 | i_src2;
            `ALU_XOR:            o_res = i_src1 ^ i_src2;
            `ALU_SLL:            o_res = i_src1 << shamt;
            `ALU_SRL:            o_res = i_src1 >> shamt;
            `ALU_SRA:            o_res = $signed(i_src1) >>> shamt;
            default:             o_res = '0;
        endcase
    end
endmodule

module exu_stage #(
    parameter int XLEN  = `CPU_WIDTH,      // must equal `CPU_WIDTH
    parameter int OPT_W = `EXU_OPT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_src1,
    input  logic [XLEN-1:0]  i_src2,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [OPT_W-1:0] i_opt,
    input  logic [2:0]       i_brch,
    input  logic             i_jalr,
    input  logic [1:0]       i_res_sel,
    input  logic [4:0]       i_rd,
    input  logic             i_wen,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_res,
    output logic [4:0]       o_rd,
    output logic             o_wen,
    output logic             o_redir_valid,
    output logic [XLEN-1:0]  o_redir_pc
);
    typedef enum logic [2:0] {
        BR_NONE = 3'd0, BR_EQ  = 3'd1, BR_NE  = 3'd2, BR_LT = 3'd3,
        BR_GE   = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6, BR_JMP = 3'd7
    } brch_e;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0, RS_SLT = 2'd1, RS_SLTU = 2'd2, RS_LINK = 2'd3
    } res_sel_e;

    brch_e            brch;
    res_sel_e         res_sel;
    logic [OPT_W-1:0] alu_opt;
    logic [XLEN-1:0]  alu_res;
    logic             alu_borrow;
    logic             is_cond;
    logic             lt, ltu, eq;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  res_next;
    logic             wen_next;
    logic             accept;
    logic             load;

    assign brch    = brch_e'(i_brch);
    assign res_sel = res_sel_e'(i_res_sel);
    assign is_cond = (brch != BR_NONE) && (brch != BR_JMP);

    // Comparisons need a subtract; branches take priority over set-less-than.
    always_comb begin
        alu_opt = i_opt;
        case (brch)
            BR_EQ, BR_NE, BR_LT, BR_GE: alu_opt = `ALU_SUB;
            BR_LTU, BR_GEU:             alu_opt = `ALU_SUBU;
            default: begin
                if (res_sel == RS_SLT)       alu_opt = `ALU_SUB;
                else if (res_sel == RS_SLTU) alu_opt = `ALU_SUBU;
            end
        endcase
    end

    exu_alu #(.XLEN(XLEN), .OPT_W(OPT_W)) u_alu (
        .i_opt     (alu_opt),
        .i_src1    (i_src1),
        .i_src2    (i_src2),
        .o_res     (alu_res),
        .o_sububit (alu_borrow)
    );

    // Signed compare: differing signs decide directly, otherwise the difference sign does.
    assign lt  = (i_src1[XLEN-1] ^ i_src2[XLEN-1]) ? i_src1[XLEN-1] : alu_res[XLEN-1];
    assign ltu = alu_borrow;
    assign eq  = (alu_res == '0);

    // Branch decision, redirect target, writeback value and write enable.
    always_comb begin
        taken = 1'b0;
        case (brch)
            BR_EQ:   taken = eq;
            BR_NE:   taken = !eq;
            BR_LT:   taken = lt;
            BR_GE:   taken = !lt;
            BR_LTU:  taken = ltu;
            BR_GEU:  taken = !ltu;
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase

        if ((brch == BR_JMP) && i_jalr)
            target = (i_src1 + i_imm) & ~XLEN'(1);
        else
            target = i_pc + i_imm;

        case (res_sel)
            RS_SLT:  res_next = XLEN'(lt);
            RS_SLTU: res_next = XLEN'(ltu);
            RS_LINK: res_next = i_pc + XLEN'(4);
            default: res_next = alu_res;
        endcase

        wen_next = i_wen && !is_cond && (i_rd != 5'd0);
    end

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    // Wrong-path instructions arriving with the redirect pulse are consumed but dropped.
    assign load    = accept && !i_flush && !o_redir_valid;

    // Output register, redirect pulse and handshake state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_res         <= '0;
            o_rd          <= '0;
            o_wen         <= 1'b0;
            o_redir_valid <= 1'b0;
            o_redir_pc    <= '0;
        end else begin
            if (i_flush)
                o_valid <= 1'b0;
            else if (load)
                o_valid <= 1'b1;
            else if (i_ready)
                o_valid <= 1'b0;

            if (load) begin
                o_res <= res_next;
                o_rd  <= i_rd;
                o_wen <= wen_next;
            end

            o_redir_valid <= load && taken;
            if (load && taken)
                o_redir_pc <= target;
        end
    end
endmodule

// File: tb/tb_exu_stage.sv
// Self-checking bench for exu_stage: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.

`ifndef ALU_ADD
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_SUBU 4'h2
`define ALU_AND  4'h3
`define ALU_OR   4'h4
`define ALU_XOR  4'h5
`define ALU_SLL  4'h6
`define ALU_SRL  4'h7
`define ALU_SRA  4'h8
`endif

module tb_exu_stage;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, valid, ready_o, jalr, wen, flush, ready_i;
    logic [31:0] pc, src1, src2, imm;
    logic [3:0]  opt;
    logic [2:0]  brch;
    logic [1:0]  res_sel;
    logic [4:0]  rd;
    logic        valid_o, wen_o, redir_valid;
    logic [31:0] res_o, redir_pc;
    logic [4:0]  rd_o;

    always #5 clk = ~clk;

    exu_stage #(.XLEN(XLEN), .OPT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_o),
        .i_pc(pc), .i_src1(src1), .i_src2(src2), .i_imm(imm), .i_opt(opt),
        .i_brch(brch), .i_jalr(jalr), .i_res_sel(res_sel), .i_rd(rd),
        .i_wen(wen), .i_flush(flush), .o_valid(valid_o), .i_ready(ready_i),
        .o_res(res_o), .o_rd(rd_o), .o_wen(wen_o),
        .o_redir_valid(redir_valid), .o_redir_pc(redir_pc)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, src1, src2, imm;
        logic [3:0]  opt;
        logic [2:0]  brch;
        logic        jalr;
        logic [1:0]  res_sel;
        logic [4:0]  rd;
        logic        wen;
    } ins_t;

    // Model of the architecturally visible output state.
    logic        m_valid = 1'b0, m_wen = 1'b0, m_rv = 1'b0;
    logic [31:0] m_res = '0, m_rpc = '0;
    logic [4:0]  m_rd = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic ins_t bubble();
        ins_t t;
        t = '{valid: 1'b0, pc: '0, src1: '0, src2: '0, imm: '0, opt: '0,
              brch: '0, jalr: 1'b0, res_sel: '0, rd: '0, wen: 1'b0};
        return t;
    endfunction

    // Plain-arithmetic reference of what one instruction produces.
    function automatic void ref_exec(input ins_t t, output logic [31:0] r,
                                     output logic w, output logic tk,
                                     output logic [31:0] tgt);
        logic        slt, sltu, cond;
        logic [31:0] alu;
        slt  = $signed(t.src1) < $signed(t.src2);
        sltu = t.src1 < t.src2;
        cond = (t.brch >= 3'd1) && (t.brch <= 3'd6);
        if (cond || t.res_sel == 2'd1 || t.res_sel == 2'd2)
            alu = t.src1 - t.src2;
        else case (t.opt)
            `ALU_ADD:            alu = t.src1 + t.src2;
            `ALU_SUB, `ALU_SUBU: alu = t.src1 - t.src2;
            `ALU_AND:            alu = t.src1 & t.src2;
            `ALU_OR:             alu = t.src1 | t.src2;
            `ALU_XOR:            alu = t.src1 ^ t.src2;
            `ALU_SLL:            alu = t.src1 << t.src2[4:0];
            `ALU_SRL:            alu = t.src1 >> t.src2[4:0];
            `ALU_SRA:            alu = 32'($signed(t.src1) >>> t.src2[4:0]);
            default:             alu = 32'd0;
        endcase
        case (t.res_sel)
            2'd1:    r = {31'd0, slt};
            2'd2:    r = {31'd0, sltu};
            2'd3:    r = t.pc + 32'd4;
            default: r = alu;
        endcase
        w = t.wen && !cond && (t.rd != 5'd0);
        case (t.brch)
            3'd1: tk = t.src1 == t.src2;
            3'd2: tk = t.src1 != t.src2;
            3'd3: tk = slt;
            3'd4: tk = !slt;
            3'd5: tk = sltu;
            3'd6: tk = !sltu;
            3'd7: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        tgt = (t.brch == 3'd7 && t.jalr) ? ((t.src1 + t.imm) & 32'hFFFF_FFFE) : (t.pc + t.imm);
    endfunction

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input ins_t t, input logic r, input logic f, input logic rdy);
        logic        acc, ld, n_valid, n_wen, n_rv, w, tk;
        logic [31:0] n_res, n_rpc, rr, tgt;
        logic [4:0]  n_rd;
        @(negedge clk);
        rst = r; flush = f; ready_i = rdy;
        valid = t.valid; pc = t.pc; src1 = t.src1; src2 = t.src2; imm = t.imm;
        opt = t.opt; brch = t.brch; jalr = t.jalr; res_sel = t.res_sel;
        rd = t.rd; wen = t.wen;
        #1;
        check("o_ready", 32'(ready_o), 32'(!m_valid || rdy));

        n_valid = m_valid; n_res = m_res; n_rd = m_rd; n_wen = m_wen; n_rpc = m_rpc;
        n_rv = 1'b0;
        if (r) begin
            n_valid = 1'b0; n_res = '0; n_rd = '0; n_wen = 1'b0; n_rpc = '0;
        end else begin
            acc = t.valid && (!m_valid || rdy);
            ld  = acc && !f && !m_rv;
            ref_exec(t, rr, w, tk, tgt);
            if (f)                 n_valid = 1'b0;
            else if (ld)           n_valid = 1'b1;
            else if (m_valid && rdy) n_valid = 1'b0;
            if (ld) begin
                n_res = rr; n_rd = t.rd; n_wen = w;
                if (tk) begin
                    n_rv  = 1'b1;
                    n_rpc = tgt;
                end
            end
        end

        @(posedge clk);
        #1;
        m_valid = n_valid; m_res = n_res; m_rd = n_rd; m_wen = n_wen;
        m_rv = n_rv; m_rpc = n_rpc;
        check("o_valid", 32'(valid_o), 32'(m_valid));
        check("o_redir_valid", 32'(redir_valid), 32'(m_rv));
        check("o_res", res_o, m_res);
        check("o_rd", 32'(rd_o), 32'(m_rd));
        check("o_wen", 32'(wen_o), 32'(m_wen));
        check("o_redir_pc", redir_pc, m_rpc);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        ins_t t, a;
        t = bubble();
        step(t, 1'b1, 1'b0, 1'b1);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_res", res_o, 32'd0);

        // add 5 + 7 -> x3
        t = bubble();
        t.valid = 1'b1; t.src1 = 32'd5; t.src2 = 32'd7; t.opt = `ALU_ADD;
        t.rd = 5'd3; t.wen = 1'b1;
        step(t, 1'b0, 1'b0, 1'b1);
        check("add_res", res_o, 32'd12);
        check("add_wen", 32'(wen_o), 32'd1);

        // reset mid-stream while holding a valid output
        step(bubble(), 1'b1, 1'b0, 1'b0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_res", res_o, 32'd0);

        // slt / sltu with -1 vs 1
        t = bubble();
        t.valid = 1'b1; t.src1 = 32'hFFFF_FFFF; t.src2 = 32'd1; t.res_sel = 2'd1;
        t.rd = 5'd4; t.wen = 1'b1;
        step(t, 1'b0, 1'b0, 1'b1);
        check("slt_res", res_o, 32'd1);
        t.res_sel = 2'd2;
        step(t, 1'b0, 1'b0, 1'b1);
        check("sltu_res", res_o, 32'd0);

        // taken bltu; the instruction after it is squashed
        t = bubble();
        t.valid = 1'b1; t.src1 = 32'd1; t.src2 = 32'hFFFF_FFFF; t.brch = 3'd5;
        t.pc = 32'h8000_0000; t.imm = 32'h10; t.rd = 5'd5; t.wen = 1'b1;
        step(t, 1'b0, 1'b0, 1'b1);
        check("bltu_redir", 32'(redir_valid), 32'd1);
        check("bltu_pc", redir_pc, 32'h8000_0010);
        check("bltu_wen", 32'(wen_o), 32'd0);
        t = bubble();
        t.valid = 1'b1; t.src1 = 32'd9; t.rd = 5'd6; t.wen = 1'b1;
        step(t, 1'b0, 1'b0, 1'b1);
        check("squash_valid", 32'(valid_o), 32'd0);
        check("squash_redir", 32'(redir_valid), 32'd0);

        // jalr with link
        t = bubble();
        t.valid = 1'b1; t.src1 = 32'h8000_1003; t.imm = 32'd4; t.res_sel = 2'd3;
        t.pc = 32'h8000_0100; t.brch = 3'd7; t.jalr = 1'b1; t.rd = 5'd1; t.wen = 1'b1;
        step(t, 1'b0, 1'b0, 1'b1);
        check("jalr_link", res_o, 32'h8000_0104);
        check("jalr_pc", redir_pc, 32'h8000_1006);
        step(bubble(), 1'b0, 1'b0, 1'b1);

        // backpressure: hold A for three cycles, then drain+accept B
        a = bubble();
        a.valid = 1'b1; a.src1 = 32'd100; a.src2 = 32'd1; a.opt = `ALU_ADD;
        a.rd = 5'd7; a.wen = 1'b1;
        step(a, 1'b0, 1'b0, 1'b0);
        t = a; t.src1 = 32'd200; t.rd = 5'd8;
        for (int i = 0; i < 3; i++) begin
            step(t, 1'b0, 1'b0, 1'b0);
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_res", res_o, 32'd101);
        end
        step(t, 1'b0, 1'b0, 1'b1);
        check("drain_valid", 32'(valid_o), 32'd1);
        check("drain_res", res_o, 32'd201);
        step(a, 1'b0, 1'b0, 1'b0);
        step(t, 1'b0, 1'b1, 1'b0);
        check("flush_valid", 32'(valid_o), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            t.valid   = ($urandom_range(0, 3) != 0);
            t.pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            t.src1    = pick_val();
            t.src2    = ($urandom_range(0, 3) == 0) ? t.src1 : pick_val();
            t.imm     = pick_val();
            t.opt     = 4'($urandom_range(0, 8));
            t.brch    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            t.jalr    = 1'($urandom_range(0, 1));
            t.res_sel = 2'($urandom_range(0, 3));
            t.rd      = 5'($urandom_range(0, 31));
            t.wen     = 1'($urandom_range(0, 1));
            step(t, ($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
